// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants, request record and address checker for mem_arbiter.
package mem_arb_pkg;

    localparam logic [1:0]  MEM_WIDTH_B          = 2'b01;
    localparam logic [1:0]  MEM_WIDTH_H          = 2'b10;
    localparam logic [1:0]  MEM_WIDTH_W          = 2'b11;
    localparam logic [31:0] BASE_ADDRESS_DEFAULT = 32'h0100_0000;

    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_BUSY = 1'b1;

    localparam logic [0:0]  PORT_F  = 1'b0;
    localparam logic [0:0]  PORT_D  = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic [1:0]  width;
        logic        sgn;
        logic [0:0]  port;
        logic        err;
    } req_t;

    // Misaligned, below base, or running past limit (one past the last valid byte).
    // Width code 00 has no defined size and is rejected as well.
    function automatic logic access_err(input logic [31:0] addr, input logic [1:0] width,
                                        input logic [31:0] base, input logic [32:0] limit);
        logic [2:0]  size;
        logic        misalign;
        logic [32:0] end_addr;
        case (width)
            MEM_WIDTH_B: begin size = 3'd1; misalign = 1'b0;      end
            MEM_WIDTH_H: begin size = 3'd2; misalign = addr[0];   end
            MEM_WIDTH_W: begin size = 3'd4; misalign = |addr[1:0]; end
            default:     begin size = 3'd4; misalign = 1'b1;      end
        endcase
        end_addr = {1'b0, addr} + {30'd0, size};
        return misalign || (addr < base) || (end_addr > limit);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: one-hot grant between fetch and data requesters.
// With RR_EN the port not granted last wins a tie; otherwise data always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic       if_valid_i,
    input  logic       d_valid_i,
    input  logic       last_d_i,
    output logic [1:0] grant_o
);

    logic d_wins;

    // data yields only on a tie when round-robin says it went last
    always_comb begin
        d_wins           = d_valid_i && !(RR_EN && if_valid_i && last_d_i);
        grant_o          = '0;
        grant_o[PORT_D]  = d_wins;
        grant_o[PORT_F]  = if_valid_i && !d_wins;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data two-port arbiter onto one combinational memory.
// Every request occupies IDLE(accept) + BUSY(access); response pulses the cycle after BUSY.
// Optional macro MEM_ARBITER_ROUND_ROBIN_EN: alternate grants on ties instead of data priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = BASE_ADDRESS_DEFAULT,
    parameter int unsigned DEPTH        = 10**6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_write,
    input  logic [1:0]  d_width,
    input  logic        d_signed,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read_write,
    output logic [1:0]  mem_width,
    output logic        mem_signed_read,
    input  logic [31:0] mem_data_out
);

    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDRESS} + 33'(DEPTH);

    logic [0:0]  state_q, state_d;
    logic [1:0]  grant;
    logic        last_d, idle, busy, accept;
    req_t        req_q, req_d;
    logic        if_rsp_valid_q, d_rsp_valid_q, if_rsp_err_q, d_rsp_err_q;
    logic [31:0] if_rsp_data_q, d_rsp_data_q, rsp_data_d;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
    logic last_d_q;
    // remember which port won the latest acceptance; reset leaves fetch as last
    always_ff @(posedge clock or posedge reset) begin
        if (reset)       last_d_q <= 1'b0;
        else if (accept) last_d_q <= grant[PORT_D];
    end
    assign last_d = last_d_q;
`else
    localparam bit RR_EN = 1'b0;
    assign last_d = 1'b0;
`endif

    mem_arb_pick #(.RR_EN(RR_EN)) u_pick (
        .if_valid_i (if_req_valid),
        .d_valid_i  (d_req_valid),
        .last_d_i   (last_d),
        .grant_o    (grant)
    );

    assign idle         = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_BUSY);
    assign if_req_ready = !reset && idle && grant[PORT_F];
    assign d_req_ready  = !reset && idle && grant[PORT_D];
    assign accept       = if_req_ready || d_req_ready;

    // capture the granted port's request; fetch is always an unsigned word read
    always_comb begin
        req_d = '0;
        if (grant[PORT_D]) begin
            req_d.addr  = d_addr;
            req_d.wdata = d_wdata;
            req_d.write = d_write;
            req_d.width = d_width;
            req_d.sgn   = d_signed;
            req_d.port  = PORT_D;
        end else begin
            req_d.addr  = if_addr;
            req_d.width = MEM_WIDTH_W;
            req_d.port  = PORT_F;
        end
        req_d.err = access_err(req_d.addr, req_d.width, BASE_ADDRESS, LIMIT);
    end

    // IDLE -> BUSY on acceptance, BUSY always lasts a single cycle
    always_comb begin
        state_d = state_q;
        if (busy)        state_d = ST_IDLE;
        else if (accept) state_d = ST_BUSY;
    end

    // state and latched request
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) req_q <= req_d;
        end
    end

    assign rsp_data_d = (req_q.err || req_q.write) ? '0 : mem_data_out;

    // response pulse and held data/err for the port that owned the BUSY cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            if_rsp_valid_q <= 1'b0;
            d_rsp_valid_q  <= 1'b0;
            if_rsp_err_q   <= 1'b0;
            d_rsp_err_q    <= 1'b0;
            if_rsp_data_q  <= '0;
            d_rsp_data_q   <= '0;
        end else begin
            if_rsp_valid_q <= busy && (req_q.port == PORT_F);
            d_rsp_valid_q  <= busy && (req_q.port == PORT_D);
            if (busy && req_q.port == PORT_F) begin
                if_rsp_data_q <= rsp_data_d;
                if_rsp_err_q  <= req_q.err;
            end
            if (busy && req_q.port == PORT_D) begin
                d_rsp_data_q <= rsp_data_d;
                d_rsp_err_q  <= req_q.err;
            end
        end
    end

    assign if_rsp_valid = if_rsp_valid_q;
    assign if_rsp_data  = if_rsp_data_q;
    assign if_rsp_err   = if_rsp_err_q;
    assign d_rsp_valid  = d_rsp_valid_q;
    assign d_rsp_data   = d_rsp_data_q;
    assign d_rsp_err    = d_rsp_err_q;

    // memory sees the request only in BUSY; a faulting store never drives a write
    always_comb begin
        mem_address     = BASE_ADDRESS;
        mem_data_in     = '0;
        mem_read_write  = 1'b1;
        mem_width       = MEM_WIDTH_W;
        mem_signed_read = 1'b0;
        if (busy) begin
            mem_address     = req_q.addr;
            mem_data_in     = req_q.wdata;
            mem_read_write  = !(req_q.write && !req_q.err);
            mem_width       = req_q.width;
            mem_signed_read = req_q.sgn;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + random checks of mem_arbiter against a byte-level memory model.
module tb_mem_arbiter;

    localparam logic [31:0] BASE   = 32'h0100_0000;
    localparam int unsigned DEPTH  = 1000000;
    localparam longint      BASE_L = 64'h0100_0000;
    localparam longint      END_L  = 64'h0100_0000 + 64'd1000000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [31:0] if_addr, if_rsp_data;
    logic        d_req_valid, d_req_ready, d_write, d_signed, d_rsp_valid, d_rsp_err;
    logic [31:0] d_addr, d_wdata, d_rsp_data;
    logic [1:0]  d_width;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_read_write, mem_signed_read;
    logic [1:0]  mem_width;

    int errors = 0, checks = 0;
    int f_rsp_cnt = 0, d_rsp_cnt = 0, wr_cnt = 0;

    // two 256-byte windows: just above BASE and just below BASE+DEPTH
    logic [7:0] env_mem [512];
    logic [7:0] ref_mem [512];

    always #5 clock = ~clock;

    mem_arbiter #(.BASE_ADDRESS(BASE), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_write(d_write), .d_width(d_width), .d_signed(d_signed),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_read_write(mem_read_write),
        .mem_width(mem_width), .mem_signed_read(mem_signed_read), .mem_data_out(mem_data_out)
    );

    function automatic int idx(input logic [31:0] a);
        longint la;
        la = longint'({32'd0, a});
        if (la >= BASE_L && la < BASE_L + 256) return int'(la - BASE_L);
        if (la >= END_L - 256 && la < END_L) return int'(la - (END_L - 256)) + 256;
        return -1;
    endfunction

    function automatic int wsize(input logic [1:0] w);
        return (w == 2'b01) ? 1 : (w == 2'b10) ? 2 : 4;
    endfunction

    // memory device: little-endian bytes, extension done by the memory itself
    function automatic logic [31:0] env_read(input logic [31:0] a, input logic [1:0] w, input logic s);
        logic [7:0] b [4];
        int i;
        for (int k = 0; k < 4; k++) begin
            i = idx(a + 32'(k));
            b[k] = (i < 0) ? 8'hA5 : env_mem[i];
        end
        case (w)
            2'b01:   return {{24{s & b[0][7]}}, b[0]};
            2'b10:   return {{16{s & b[1][7]}}, b[1], b[0]};
            default: return {b[3], b[2], b[1], b[0]};
        endcase
    endfunction

    always @(negedge clock) mem_data_out = env_read(mem_address, mem_width, mem_signed_read);

    always @(posedge clock) begin
        int i;
        if (!reset && mem_read_write === 1'b0)
            for (int k = 0; k < wsize(mem_width); k++) begin
                i = idx(mem_address + 32'(k));
                if (i >= 0) env_mem[i] = mem_data_in[8*k +: 8];
            end
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (if_rsp_valid === 1'b1) f_rsp_cnt++;
            if (d_rsp_valid === 1'b1) d_rsp_cnt++;
            if (mem_read_write === 1'b0) wr_cnt++;
        end
    end

    // reference model: access legality and value by plain arithmetic
    function automatic bit model_err(input logic [31:0] a, input int n);
        longint la;
        la = longint'({32'd0, a});
        return (la % n != 0) || (la < BASE_L) || (la + n > END_L);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n, input bit s);
        longint v;
        v = 0;
        for (int k = n - 1; k >= 0; k--) v = v * 256 + longint'(ref_mem[idx(a + 32'(k))]);
        if (s && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    function automatic void model_write(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int k = 0; k < n; k++) ref_mem[idx(a + 32'(k))] = 8'(d >> (8 * k));
    endfunction

    // drives one request from posedge+1, returns at posedge+1 of the response cycle
    task automatic run_req(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit wr, input logic [1:0] wd, input bit sg,
                           output bit acc, output int wait_n, output bit rsp_ok,
                           output logic [31:0] data, output logic err);
        bit quiet;
        acc = 0; wait_n = 0; rsp_ok = 0; data = '0; err = 1'b0;
        if (port) begin
            d_addr = addr; d_wdata = wdata; d_write = wr; d_width = wd; d_signed = sg;
            d_req_valid = 1'b1;
        end else begin
            if_addr = addr; if_req_valid = 1'b1;
        end
        #1;
        while (!acc && wait_n < 20) begin
            acc = port ? d_req_ready : if_req_ready;
            @(posedge clock); #1;
            if (!acc) wait_n++;
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        if (acc) begin
            quiet = !if_rsp_valid && !d_rsp_valid;
            @(posedge clock); #1;
            rsp_ok = quiet && (port ? (d_rsp_valid && !if_rsp_valid) : (if_rsp_valid && !d_rsp_valid));
            data   = port ? d_rsp_data : if_rsp_data;
            err    = port ? d_rsp_err : if_rsp_err;
        end
    endtask

    task automatic do_reset();
        if_req_valid = 1'b0; d_req_valid = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        if_addr = BASE; d_addr = BASE; d_width = 2'b11; d_write = 1'b1; d_wdata = 32'h1;
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        @(posedge clock); #1;
        checks++; if ({if_req_ready, d_req_ready} !== 2'b00) begin errors++;
            $display("FAIL reset_ready: got %b want 00", {if_req_ready, d_req_ready}); end
        checks++; if ({if_rsp_valid, d_rsp_valid, if_rsp_err, d_rsp_err} !== 4'b0) begin errors++;
            $display("FAIL reset_rsp: got %b want 0000", {if_rsp_valid, d_rsp_valid, if_rsp_err, d_rsp_err}); end
        checks++; if ({if_rsp_data, d_rsp_data} !== 64'd0) begin errors++;
            $display("FAIL reset_data: got %h %h want 0", if_rsp_data, d_rsp_data); end
        checks++; if ({mem_read_write, mem_width, mem_signed_read} !== 4'b1110) begin errors++;
            $display("FAIL reset_memctl: got %b want 1110", {mem_read_write, mem_width, mem_signed_read}); end
        checks++; if ({mem_address, mem_data_in} !== {BASE, 32'd0}) begin errors++;
            $display("FAIL reset_memaddr: got %h %h want %h 0", mem_address, mem_data_in, BASE); end
        if_req_valid = 1'b0; d_req_valid = 1'b0; reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_fetch_read();
        bit acc, ok; int w; logic [31:0] data; logic err; int f0;
        {env_mem[3], env_mem[2], env_mem[1], env_mem[0]} = 32'hDEADBEEF;
        {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]} = 32'hDEADBEEF;
        f0 = f_rsp_cnt;
        run_req(1'b0, BASE, 32'd0, 1'b0, 2'b11, 1'b0, acc, w, ok, data, err);
        checks++; if (!(acc && w == 0)) begin errors++;
            $display("FAIL fetch_ready_cycle0: acc=%0d wait=%0d want acc=1 wait=0", acc, w); end
        checks++; if (!ok) begin errors++;
            $display("FAIL fetch_rsp_cycle2: got no pulse want pulse on fetch port"); end
        checks++; if ({data, err} !== {32'hDEADBEEF, 1'b0}) begin errors++;
            $display("FAIL fetch_data: got %h err %b want deadbeef err 0", data, err); end
        repeat (2) @(posedge clock); #1;
        checks++; if (f_rsp_cnt - f0 !== 1) begin errors++;
            $display("FAIL fetch_pulse_len: got %0d cycles want 1", f_rsp_cnt - f0); end
    endtask

    task automatic test_signed_byte();
        bit acc, ok; int w; logic [31:0] data; logic err;
        env_mem[5] = 8'h80; ref_mem[5] = 8'h80;
        run_req(1'b1, BASE + 5, 32'd0, 1'b0, 2'b01, 1'b1, acc, w, ok, data, err);
        checks++; if (!(acc && ok) || {data, err} !== {32'hFFFF_FF80, 1'b0}) begin errors++;
            $display("FAIL byte_signed: got %h err %b ok %b want ffffff80", data, err, ok); end
        run_req(1'b1, BASE + 5, 32'd0, 1'b0, 2'b01, 1'b0, acc, w, ok, data, err);
        checks++; if (!(acc && ok) || {data, err} !== {32'h0000_0080, 1'b0}) begin errors++;
            $display("FAIL byte_unsigned: got %h err %b ok %b want 00000080", data, err, ok); end
    endtask

    task automatic test_bounds();
        bit acc, ok; int w; logic [31:0] data; logic err; logic [31:0] exp_d;
        logic [31:0] addrs [7];
        logic [1:0]  wds   [7];
        bit          exp_e [7];
        addrs = '{32'h00FF_FFFC, 32'(END_L - 2), 32'(END_L - 2), 32'(END_L - 1),
                  32'(END_L), 32'(END_L - 4), BASE - 1};
        wds   = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b01, 2'b11, 2'b01};
        exp_e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            exp_d = exp_e[i] ? 32'd0 : model_read(addrs[i], wsize(wds[i]), 1'b0);
            run_req(1'b1, addrs[i], 32'd0, 1'b0, wds[i], 1'b0, acc, w, ok, data, err);
            checks++; if (!(acc && ok) || {data, err} !== {exp_d, exp_e[i]}) begin errors++;
                $display("FAIL bounds_%0d: addr %h got %h err %b ok %b want %h err %b",
                         i, addrs[i], data, err, ok, exp_d, exp_e[i]); end
        end
    endtask

    task automatic test_misaligned_store();
        bit acc, ok; int w; logic [31:0] data; logic err; int w0;
        w0 = wr_cnt;
        run_req(1'b1, BASE + 2, 32'h12345678, 1'b1, 2'b11, 1'b0, acc, w, ok, data, err);
        checks++; if (!(acc && ok) || {data, err} !== {32'd0, 1'b1}) begin errors++;
            $display("FAIL misaligned_store_rsp: got %h err %b ok %b want 0 err 1", data, err, ok); end
        checks++; if (wr_cnt !== w0) begin errors++;
            $display("FAIL misaligned_store_write: got %0d write cycles want 0", wr_cnt - w0); end
        checks++; if ({env_mem[5], env_mem[4], env_mem[3], env_mem[2]} !==
                      {ref_mem[5], ref_mem[4], ref_mem[3], ref_mem[2]}) begin errors++;
            $display("FAIL misaligned_store_mem: got %h want %h",
                     {env_mem[5], env_mem[4], env_mem[3], env_mem[2]},
                     {ref_mem[5], ref_mem[4], ref_mem[3], ref_mem[2]}); end
        w0 = wr_cnt;
        run_req(1'b1, BASE + 8, 32'h5555BEEF, 1'b1, 2'b10, 1'b0, acc, w, ok, data, err);
        model_write(BASE + 8, 2, 32'h5555BEEF);
        checks++; if (!(acc && ok) || {data, err} !== {32'd0, 1'b0} || wr_cnt - w0 !== 1) begin errors++;
            $display("FAIL store_h_rsp: got %h err %b ok %b writes %0d want 0 err 0 writes 1",
                     data, err, ok, wr_cnt - w0); end
        run_req(1'b1, BASE + 8, 32'd0, 1'b0, 2'b11, 1'b0, acc, w, ok, data, err);
        checks++; if (!(acc && ok) || data !== model_read(BASE + 8, 4, 1'b0)) begin errors++;
            $display("FAIL store_h_readback: got %h want %h", data, model_read(BASE + 8, 4, 1'b0)); end
    endtask

    task automatic test_priority();
        int d_left, f_left, k, cyc, onehot_bad, gap_bad, last_acc, d0, f0;
        logic [7:0] seq, exp_seq;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        exp_seq = 8'b1010_1010;
`else
        exp_seq = 8'b1111_0000;
`endif
        do_reset();
        d0 = d_rsp_cnt; f0 = f_rsp_cnt;
        d_left = 4; f_left = 4; k = 0; cyc = 0; onehot_bad = 0; gap_bad = 0; last_acc = 0; seq = '0;
        if_addr = BASE; d_addr = BASE + 4; d_write = 1'b0; d_width = 2'b11; d_signed = 1'b0;
        while (k < 8 && cyc < 60) begin
            if_req_valid = (f_left > 0); d_req_valid = (d_left > 0);
            #1;
            if (d_req_ready && if_req_ready) onehot_bad++;
            if (d_req_ready || if_req_ready) begin
                seq[7 - k] = d_req_ready;
                if (d_req_ready) d_left--; else f_left--;
                if (k > 0 && cyc - last_acc != 2) gap_bad++;
                last_acc = cyc; k++;
            end
            @(posedge clock); #1; cyc++;
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (k !== 8 || onehot_bad !== 0 || gap_bad !== 0) begin errors++;
            $display("FAIL b2b_accepts: got %0d accepts, %0d double, %0d bad gaps want 8 0 0",
                     k, onehot_bad, gap_bad); end
        checks++; if (seq !== exp_seq) begin errors++;
            $display("FAIL grant_order: got %b want %b (1=data)", seq, exp_seq); end
        checks++; if (d_rsp_cnt - d0 !== 4 || f_rsp_cnt - f0 !== 4) begin errors++;
            $display("FAIL b2b_rsp_count: got d=%0d f=%0d want 4 4", d_rsp_cnt - d0, f_rsp_cnt - f0); end
    endtask

    task automatic test_reset_mid_busy();
        int d0;
        d0 = d_rsp_cnt;
        d_addr = BASE + 16; d_wdata = 32'hCAFEF00D; d_write = 1'b1; d_width = 2'b11; d_signed = 1'b0;
        d_req_valid = 1'b1;
        #1;
        checks++; if (d_req_ready !== 1'b1) begin errors++;
            $display("FAIL rstbusy_ready: got %b want 1", d_req_ready); end
        @(posedge clock); #1;
        d_req_valid = 1'b0;
        checks++; if ({mem_read_write, mem_address} !== {1'b0, BASE + 32'd16}) begin errors++;
            $display("FAIL rstbusy_drive: got rw %b addr %h want 0 %h", mem_read_write, mem_address, BASE + 16); end
        reset = 1'b1;
        #1;
        checks++; if (mem_read_write !== 1'b1) begin errors++;
            $display("FAIL rstbusy_rw: got %b want 1", mem_read_write); end
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checks++; if (d_rsp_cnt !== d0) begin errors++;
            $display("FAIL rstbusy_rsp: got %0d responses want 0", d_rsp_cnt - d0); end
        checks++; if ({env_mem[19], env_mem[18], env_mem[17], env_mem[16]} !==
                      {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]}) begin errors++;
            $display("FAIL rstbusy_mem: got %h want %h", {env_mem[19], env_mem[18], env_mem[17], env_mem[16]},
                     {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]}); end
    endtask

    task automatic test_withdraw();
        int d0, f0;
        d0 = d_rsp_cnt; f0 = f_rsp_cnt;
        if_addr = BASE; d_addr = BASE + 4; d_write = 1'b0; d_width = 2'b11; d_signed = 1'b0;
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        #1;
        checks++; if ({d_req_ready, if_req_ready} !== 2'b10) begin errors++;
            $display("FAIL withdraw_grant: got %b want 10", {d_req_ready, if_req_ready}); end
        @(posedge clock); #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checks++; if (f_rsp_cnt - f0 !== 0 || d_rsp_cnt - d0 !== 1) begin errors++;
            $display("FAIL withdraw_rsp: got f=%0d d=%0d want 0 1", f_rsp_cnt - f0, d_rsp_cnt - d0); end
    endtask

    task automatic test_random();
        bit acc, ok, port, wr, sg, exp_err; int w, n, sel, mism;
        logic [31:0] data, addr, wdata, exp_data; logic err; logic [1:0] wd;
        for (int r = 0; r < 40; r++) begin
            port = 1'($urandom_range(0, 1));
            if (port) begin
                wd = 2'($urandom_range(1, 3)); sg = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
            end else begin
                wd = 2'b11; sg = 1'b0; wr = 1'b0;
            end
            sel = int'($urandom_range(0, 9));
            if (sel < 7)      addr = BASE + $urandom_range(0, 250);
            else if (sel < 9) addr = 32'(END_L - 8) + $urandom_range(0, 10);
            else              addr = BASE - $urandom_range(1, 4);
            wdata    = $urandom();
            n        = wsize(wd);
            exp_err  = model_err(addr, n);
            exp_data = (exp_err || wr) ? 32'd0 : model_read(addr, n, sg);
            run_req(port, addr, wdata, wr, wd, sg, acc, w, ok, data, err);
            if (!exp_err && wr) model_write(addr, n, wdata);
            checks++; if (!(acc && ok) || {data, err} !== {exp_data, exp_err}) begin errors++;
                $display("FAIL random_%0d: port %b addr %h w %b s %b wr %b got %h err %b ok %b want %h err %b",
                         r, port, addr, wd, sg, wr, data, err, ok, exp_data, exp_err); end
        end
        mism = 0;
        for (int i = 0; i < 512; i++) if (env_mem[i] !== ref_mem[i]) mism++;
        checks++; if (mism !== 0) begin errors++;
            $display("FAIL random_mem_image: got %0d differing bytes want 0", mism); end
    endtask

    initial begin
        if_req_valid = 1'b0; d_req_valid = 1'b0; if_addr = '0; d_addr = '0; d_wdata = '0;
        d_write = 1'b0; d_width = 2'b11; d_signed = 1'b0; mem_data_out = '0;
        for (int i = 0; i < 512; i++) begin
            env_mem[i] = 8'($urandom());
            ref_mem[i] = env_mem[i];
        end
        test_reset();
        test_fetch_read();
        test_signed_byte();
        test_bounds();
        test_misaligned_store();
        test_priority();
        test_reset_mid_busy();
        test_withdraw();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h0100_0000, lowest valid byte address.
REQ-002 SHALL have parameter DEPTH, default 10**6, number of valid bytes above BASE_ADDRESS.
REQ-003 SHALL use one clock; reset is asynchronous and active-high: clock  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 if_req_valid / if_req_ready  input / output  1  fetch-port request handshake.
REQ-006 if_addr  input  32  fetch byte address; always a 32-bit unsigned read.
REQ-007 if_rsp_valid  output  1; if_rsp_data  output  32; if_rsp_err  output  1  fetch response.
REQ-008 d_req_valid / d_req_ready  input / output  1  data-port request handshake.
REQ-009 d_addr  input  32; d_wdata  input  32; d_write  input  1 (1=store); d_width  input  2 (01 B, 10 H, 11 W); d_signed  input  1.
REQ-010 d_rsp_valid  output  1; d_rsp_data  output  32; d_rsp_err  output  1  data response.
REQ-011 mem_address  output  32; mem_data_in  output  32; mem_read_write  output  1 (0=write); mem_width  output  2; mem_signed_read  output  1.
REQ-012 mem_data_out  input  32  combinational read data from the memory.

Function
REQ-013 SHALL implement FSM with states IDLE and BUSY; each request takes exactly 2 cycles.
REQ-014 IDLE: x_req_ready = 1 only for the port the pick logic selects, and only if that port's x_req_valid = 1; at most one ready per cycle.
REQ-015 Acceptance (valid && ready at edge) SHALL latch address, wdata, write, width, signed, port id; IDLE -> BUSY.
REQ-016 BUSY: drive the latched request to mem_*; mem_read_write = ~write; BUSY -> IDLE unconditionally at the next edge.
REQ-017 Store commits at the edge ending BUSY; read data SHALL be registered from mem_data_out at that same edge.
REQ-018 x_rsp_valid SHALL pulse for exactly one cycle (the IDLE cycle after BUSY) on the owning port; rsp_data held until the next response.
REQ-019 Store response: rsp_valid pulses, rsp_data = 0.
REQ-020 Outside BUSY: mem_read_write = 1, mem_width = 11, mem_signed_read = 0, mem_address = BASE_ADDRESS, mem_data_in = 0; no write can ever occur outside BUSY.
REQ-021 Error: H at odd address, W with address[1:0] != 0, address < BASE_ADDRESS, or address + size > BASE_ADDRESS + DEPTH SHALL set rsp_err = 1, rsp_data = 0, and hold mem_read_write = 1 through BUSY (store suppressed).
REQ-022 Default pick (macro absent): data port has fixed priority over fetch when both valid.
REQ-023 A request accepted in the IDLE cycle that carries a response pulse is legal (back-to-back: one accept every 2 cycles).
REQ-024 Deasserting x_req_valid before acceptance SHALL withdraw the request with no side effect.

Reset
REQ-025 reset SHALL force state IDLE, all ready/rsp_valid/rsp_err = 0, rsp_data = 0, mem_* to REQ-020 idle values, RR pointer = fetch-last.
REQ-026 reset during BUSY SHALL abort: no store commits, no response is ever issued for the aborted request.

Configuration
REQ-027 Macro MEM_ARBITER_ROUND_ROBIN_EN defined: when both valid, grant the port not granted last; pointer updates on each acceptance; after reset data wins first.
REQ-028 Macro absent: REQ-022 fixed priority; no pointer register exists.

Structure
REQ-029 Package mem_arb_pkg SHALL hold MEM_WIDTH_B/H/W constants, BASE_ADDRESS default, FSM state encoding, port-id encoding.
REQ-030 Grant selection SHALL live in sub-module mem_arb_pick (valids, pointer in; one-hot grant out).

Verification
REQ-031 Fetch W read at 0x0100_0000 holding 0xDEADBEEF -> if_req_ready cycle 0, if_rsp_valid cycle 2, data 0xDEADBEEF, err 0.
REQ-032 Data signed B read of byte 0x80 -> d_rsp_data 0xFFFF_FF80; unsigned -> 0x0000_0080.
REQ-033 Both valid every cycle for 8 requests -> macro absent: all 4 data first; macro defined: D,F,D,F,... alternating.
REQ-034 Store W 0x12345678 at 0x0100_0002 -> d_rsp_err 1, memory unchanged, mem_read_write never 0.
REQ-035 Store accepted, reset asserted mid-BUSY -> mem_read_write returns to 1 immediately, memory unchanged, no d_rsp_valid.
REQ-036 Read at 0x00FF_FFFC and at BASE+DEPTH-2 width W -> rsp_err 1, rsp_data 0.
